// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM encodings, NOP word, default reset PC and the {pc,inst} queue entry.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small sync FIFO of {pc,inst} entries; head is read from registered storage, push visible next cycle.
// Flush empties the queue and wins over a same-cycle pop; pushing into a full queue is illegal.
module inst_fetch_unit_fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (i_rst) !(i_push && o_full && !i_flush));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, runs req/ack to imem, queues {pc,inst} for decode; ack at edge N -> id_valid from N+1.
// Decode stalls stop new requests via a room check on registered queue occupancy; redirects flush and drop stale responses.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        cpu_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  if_state_e    r_state;
  if_state_e    w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic [31:0]  r_imem_addr;
  logic [31:0]  w_imem_addr_nxt;
  logic [31:0]  w_redir_pc;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_room;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_after;
  fetch_entry_t w_push_dat;
  fetch_entry_t w_head;

  assign w_redir_pc  = redirect_pc & ~32'h3;
  assign w_room      = ~w_full;
  assign w_pop       = id_valid & id_ready & cpu_en;
  assign w_flush     = redirect_valid & cpu_en;
  assign w_cnt_after = w_count + CW'(1) - CW'(w_pop);
  assign w_push_dat  = '{pc: r_fetch_pc, inst: imem_data};

  assign imem_req  = (r_state != IF_IDLE) & cpu_en;
  assign imem_addr = r_imem_addr;

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_state     <= IF_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_addr <= RESET_PC;
    end else if (cpu_en) begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_imem_addr <= w_imem_addr_nxt;
    end
  end

  // Outside IDLE, req is high whenever cpu_en is, so imem_ack alone marks completion here.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_imem_addr_nxt = r_imem_addr;
    w_push          = 1'b0;
    if (cpu_en) begin
      if (redirect_valid) begin
        w_fetch_pc_nxt = w_redir_pc;
        case (r_state)
          IF_REQ:     w_state_nxt = imem_ack ? IF_IDLE : IF_DISCARD;
          IF_DISCARD: w_state_nxt = IF_DISCARD;
          default:    w_state_nxt = IF_IDLE;
        endcase
      end else begin
        case (r_state)
          IF_IDLE: begin
            if (w_room) w_state_nxt = IF_REQ;
          end
          IF_REQ: begin
            if (imem_ack) begin
              w_push         = 1'b1;
              w_fetch_pc_nxt = r_fetch_pc + 32'd4;
              w_state_nxt    = (w_cnt_after < CW'(QUEUE_DEPTH)) ? IF_REQ : IF_IDLE;
            end
          end
          IF_DISCARD: begin
            if (imem_ack) w_state_nxt = w_room ? IF_REQ : IF_IDLE;
          end
          default: w_state_nxt = IF_IDLE;
        endcase
      end
      // A pending or stale request keeps its address until the memory answers it.
      if (w_state_nxt != IF_DISCARD && !(r_state == IF_REQ && w_state_nxt == IF_REQ && !imem_ack))
        w_imem_addr_nxt = w_fetch_pc_nxt;
    end
  end

  inst_fetch_unit_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .i_rst      (cpu_rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign id_valid = ~w_empty;
  assign id_pc    = w_empty ? 32'h0 : w_head.pc;
  assign id_inst  = w_empty ? INST_NOP : w_head.inst;

endmodule
